// File: rtl/dram_responder.sv
// dram_responder: DRAM-side channel endpoint answering line reads after LAT cycles, in order, and absorbing masked line writes.
// Define DRAM_RESPONDER_STALL_EN to add LFSR-driven backpressure on both request streams and on read-data presentation.
module dram_responder #(
  parameter int GBW       = 32,
  parameter int DBW       = 16,
  parameter int CSIZE     = 32,
  parameter int LAT       = 4,
  parameter int DEPTH     = 4,
  parameter int MEM_LINES = 256
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   dramra_rdy,
  output logic                   dramra_ack,
  input  logic [GBW-1:0]         dramra_addr,
  output logic                   dramrd_rdy,
  input  logic                   dramrd_ack,
  output logic [CSIZE*DBW-1:0]   dramrd_data,
  input  logic                   dramw_rdy,
  output logic                   dramw_ack,
  input  logic [GBW-1:0]         dramw_addr,
  input  logic [CSIZE*DBW-1:0]   dramw_data,
  input  logic [CSIZE-1:0]       dramw_mask
);
  localparam int OW = $clog2(CSIZE);
  localparam int LW = $clog2(MEM_LINES);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int AW = $clog2(LAT + 1);
  localparam int LB = CSIZE * DBW;
  logic [LB-1:0] store [MEM_LINES];
  logic [LB-1:0] qdata [DEPTH];
  logic [AW-1:0] age [DEPTH];
  logic [PW-1:0] head, tail;
  logic [PW:0]   count;
  logic [LW-1:0] rline, wline;
  logic          head_rdy, rd_can, wr_can, rd_show, rd_push, rd_pop, unused;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
`ifdef DRAM_RESPONDER_STALL_EN
  logic [15:0] lfsr;
  logic        rd_hold;
  // rd_hold keeps a presented response up until the core takes it
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      lfsr    <= 16'hACE1;
      rd_hold <= 1'b0;
    end else begin
      lfsr    <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      rd_hold <= dramrd_rdy & ~dramrd_ack;
    end
  assign rd_can  = lfsr[0];
  assign wr_can  = lfsr[1];
  assign rd_show = lfsr[2] | rd_hold;
`else
  assign rd_can  = 1'b1;
  assign wr_can  = 1'b1;
  assign rd_show = 1'b1;
`endif
  assign unused      = ^{dramra_addr, dramw_addr};
  assign rline       = dramra_addr[OW +: LW];
  assign wline       = dramw_addr[OW +: LW];
  assign head_rdy    = (count != '0) && (age[head] == AW'(LAT));
  assign dramra_ack  = ~i_rst & rd_can & (count < (PW+1)'(DEPTH)) & dramra_rdy;
  assign dramw_ack   = ~i_rst & wr_can & dramw_rdy;
  assign dramrd_rdy  = ~i_rst & head_rdy & rd_show;
  assign dramrd_data = (~i_rst && count != '0) ? qdata[head] : '0;
  assign rd_push     = dramra_ack;
  assign rd_pop      = dramrd_rdy & dramrd_ack;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) age[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) age[i] <= (age[i] == AW'(LAT)) ? age[i] : age[i] + 1'b1;
      if (rd_push) begin
        age[tail] <= '0;
        tail      <= nxt(tail);
      end
      if (rd_pop) head <= nxt(head);
      count <= count + (PW+1)'(rd_push) - (PW+1)'(rd_pop);
    end
  // Store is read combinationally, so a same-edge write is not seen by the captured read
  always_ff @(posedge i_clk) begin
    if (rd_push) qdata[tail] <= store[rline];
    for (int i = 0; i < CSIZE; i++)
      if (dramw_ack && dramw_mask[i]) store[wline][i*DBW +: DBW] <= dramw_data[i*DBW +: DBW];
  end
endmodule

// File: tb/tb_dram_responder.sv
// tb_dram_responder: directed checks of latency, masking, backpressure, read-old, reset, plus a random run against a line model.
module tb_dram_responder;
  localparam int GBW = 32, DBW = 16, CSIZE = 32, LAT = 4, DEPTH = 4, MEM_LINES = 256;
  localparam int LB = CSIZE * DBW;
  logic i_clk = 1'b0, i_rst = 1'b1;
  logic dramra_rdy, dramra_ack, dramrd_rdy, dramrd_ack, dramw_rdy, dramw_ack;
  logic [GBW-1:0] dramra_addr, dramw_addr;
  logic [LB-1:0] dramrd_data, dramw_data;
  logic [CSIZE-1:0] dramw_mask;
  int errors = 0, checks = 0;
  always #5 i_clk = ~i_clk;
  dram_responder #(.GBW(GBW), .DBW(DBW), .CSIZE(CSIZE), .LAT(LAT), .DEPTH(DEPTH), .MEM_LINES(MEM_LINES)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .dramra_rdy(dramra_rdy), .dramra_ack(dramra_ack), .dramra_addr(dramra_addr),
    .dramrd_rdy(dramrd_rdy), .dramrd_ack(dramrd_ack), .dramrd_data(dramrd_data),
    .dramw_rdy(dramw_rdy), .dramw_ack(dramw_ack), .dramw_addr(dramw_addr),
    .dramw_data(dramw_data), .dramw_mask(dramw_mask)
  );
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end
  function automatic logic [LB-1:0] fill(input logic [DBW-1:0] w);
    logic [LB-1:0] r;
    for (int i = 0; i < CSIZE; i++) r[i*DBW +: DBW] = w;
    return r;
  endfunction
  function automatic logic [LB-1:0] pat(input int line);
    logic [LB-1:0] r;
    for (int i = 0; i < CSIZE; i++) r[i*DBW +: DBW] = {line[7:0], i[7:0]};
    return r;
  endfunction
  function automatic logic [LB-1:0] rnd_line();
    logic [LB-1:0] r;
    for (int i = 0; i < LB / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction
  task automatic chk(input string tag, input logic [LB-1:0] obs, input logic [LB-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic wr(input logic [31:0] a, input logic [LB-1:0] d, input logic [CSIZE-1:0] m);
    dramw_rdy = 1'b1; dramw_addr = a; dramw_data = d; dramw_mask = m;
    #1 chk("w_ack", dramw_ack, 1);
    @(negedge i_clk);
    dramw_rdy = 1'b0;
  endtask
  task automatic rd(input logic [31:0] a);
    int n = 0;
    dramra_rdy = 1'b1; dramra_addr = a;
    #1;
    while (!dramra_ack && n < 20) begin @(negedge i_clk); #1; n++; end
    chk("ra_ack", dramra_ack, 1);
    @(negedge i_clk);
    dramra_rdy = 1'b0;
  endtask
  task automatic resp(input logic [LB-1:0] e, input string tag);
    int n = 0;
    dramrd_ack = 1'b1;
    #1;
    while (!dramrd_rdy && n < 20) begin @(negedge i_clk); #1; n++; end
    chk({tag, "_rdy"}, dramrd_rdy, 1);
    chk(tag, dramrd_data, e);
    @(negedge i_clk);
    dramrd_ack = 1'b0;
  endtask
  initial begin
    logic [LB-1:0] e, wd;
    logic [LB-1:0] mem_m [8];
    logic [LB-1:0] q [$];
    logic [CSIZE-1:0] wm;
    int acc, got, ra_line, wa_line, n;
    logic prev_hold, ra_fire, w_fire, stale;
    dramra_rdy = 1'b1; dramra_addr = '0; dramrd_ack = 1'b0;
    dramw_rdy = 1'b1; dramw_addr = '0; dramw_data = '0; dramw_mask = '0;
    repeat (3) @(negedge i_clk);
    #1;
    chk("rst_rd_rdy", dramrd_rdy, 0);
    chk("rst_ra_ack", dramra_ack, 0);
    chk("rst_w_ack", dramw_ack, 0);
    chk("rst_data", dramrd_data, 0);
    dramra_rdy = 1'b0; dramw_rdy = 1'b0; i_rst = 1'b0;
    @(negedge i_clk);
    // basic latency: rdy appears exactly LAT cycles after acceptance
    for (int i = 0; i < CSIZE; i++) e[i*DBW +: DBW] = DBW'(i);
    wr(32'h60, e, '1);
    dramra_rdy = 1'b1; dramra_addr = 32'h60;
    #1 chk("t1_ra_ack", dramra_ack, 1);
    @(negedge i_clk);
    dramra_rdy = 1'b0;
    for (int k = 0; k < LAT; k++) begin #1 chk("t1_early", dramrd_rdy, 0); @(negedge i_clk); end
    #1 chk("t1_rdy", dramrd_rdy, 1);
    chk("t1_data", dramrd_data, e);
    dramrd_ack = 1'b1;
    @(negedge i_clk);
    dramrd_ack = 1'b0;
    #1 chk("t1_pop", dramrd_rdy, 0);
    @(negedge i_clk);
    // per-word mask
    wr(32'hA0, fill(16'hFFFF), '1);
    wr(32'hA0, LB'(16'h1234), 32'h0000_0001);
    e = fill(16'hFFFF);
    e[15:0] = 16'h1234;
    rd(32'hA0);
    resp(e, "t2_mask");
    // backpressure: only DEPTH reads accepted while data is not taken
    for (int l = 0; l < 6; l++) wr(32'(l * 32), pat(l), '1);
    acc = 0;
    for (int k = 0; k < 8; k++) begin
      dramra_rdy = acc < 6; dramra_addr = 32'(acc * 32);
      #1 if (dramra_ack) acc++;
      @(negedge i_clk);
    end
    chk("t3_accepted", acc, 4);
    dramra_rdy = 1'b1; dramra_addr = 32'(4 * 32);
    #1 chk("t3_full", dramra_ack, 0);
    @(negedge i_clk);
    got = 0; dramrd_ack = 1'b1;
    for (int k = 0; k < 60 && got < 6; k++) begin
      dramra_rdy = acc < 6; dramra_addr = 32'(acc * 32);
      #1;
      if (dramrd_rdy) begin chk("t3_order", dramrd_data, pat(got)); got++; end
      if (dramra_ack) acc++;
      @(negedge i_clk);
    end
    chk("t3_count", got, 6);
    dramrd_ack = 1'b0; dramra_rdy = 1'b0;
    // same-cycle read and write to one line returns the old content
    wr(32'hE0, fill(16'hAAAA), '1);
    dramra_rdy = 1'b1; dramra_addr = 32'hE0;
    dramw_rdy = 1'b1; dramw_addr = 32'hE0; dramw_data = fill(16'h5555); dramw_mask = '1;
    #1 chk("t4_both_ack", {dramra_ack, dramw_ack}, 2'b11);
    @(negedge i_clk);
    dramra_rdy = 1'b0; dramw_rdy = 1'b0;
    resp(fill(16'hAAAA), "t4_old");
    rd(32'hE0);
    resp(fill(16'h5555), "t4_new");
    // reset with reads outstanding
    rd(32'h00); rd(32'h20); rd(32'h40);
    n = 0;
    #1;
    while (!dramrd_rdy && n < 20) begin @(negedge i_clk); #1; n++; end
    chk("t5_pending", dramrd_rdy, 1);
    i_rst = 1'b1;
    dramra_rdy = 1'b1; dramra_addr = 32'h40;
    dramw_rdy = 1'b1; dramw_addr = 32'h40; dramw_data = fill(16'hDEAD); dramw_mask = '1;
    #1;
    chk("t5_rst_rdy", dramrd_rdy, 0);
    chk("t5_rst_ra_ack", dramra_ack, 0);
    chk("t5_rst_w_ack", dramw_ack, 0);
    chk("t5_rst_data", dramrd_data, 0);
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0; dramra_rdy = 1'b0; dramw_rdy = 1'b0; dramrd_ack = 1'b1;
    stale = 1'b0;
    for (int k = 0; k < 10; k++) begin #1 stale |= dramrd_rdy; @(negedge i_clk); end
    chk("t5_stale", stale, 0);
    dramrd_ack = 1'b0;
    rd(32'h40);
    resp(pat(2), "t5_kept");
    rd(32'hE0);
    resp(fill(16'h5555), "t5_kept2");
    // random traffic against a line model on lines 8..15
    for (int l = 0; l < 8; l++) begin mem_m[l] = rnd_line(); wr(32'((8 + l) * 32), mem_m[l], '1); end
    prev_hold = 1'b0; ra_line = 0; wa_line = 0; wd = '0; wm = '0;
    for (int c = 0; c < 3000; c++) begin
      if (c >= 400 && !dramra_rdy && !dramw_rdy && q.size() == 0) break;
      if (c < 400 && !dramra_rdy && $urandom_range(1, 0) == 1) begin
        ra_line = $urandom_range(7, 0);
        dramra_rdy = 1'b1;
        dramra_addr = ($urandom & 32'hFFFF_E000) | 32'((8 + ra_line) << 5) | 32'($urandom_range(31, 0));
      end
      if (c < 400 && !dramw_rdy && $urandom_range(2, 0) == 0) begin
        wa_line = $urandom_range(7, 0); wd = rnd_line(); wm = $urandom;
        dramw_rdy = 1'b1; dramw_addr = 32'((8 + wa_line) << 5); dramw_data = wd; dramw_mask = wm;
      end
      dramrd_ack = $urandom_range(1, 0) == 1;
      #1;
      if (prev_hold) chk("t6_hold", dramrd_rdy, 1);
      if (dramrd_rdy && dramrd_ack) begin
        if (q.size() == 0) chk("t6_spurious", dramrd_rdy, 0);
        else chk("t6_data", dramrd_data, q.pop_front());
      end
      prev_hold = dramrd_rdy && !dramrd_ack;
      ra_fire = dramra_rdy && dramra_ack;
      w_fire = dramw_rdy && dramw_ack;
      if (ra_fire) q.push_back(mem_m[ra_line]);
      if (w_fire)
        for (int i = 0; i < CSIZE; i++) if (wm[i]) mem_m[wa_line][i*DBW +: DBW] = wd[i*DBW +: DBW];
      @(negedge i_clk);
      if (ra_fire) dramra_rdy = 1'b0;
      if (w_fire) dramw_rdy = 1'b0;
    end
    chk("t6_drained", q.size(), 0);
    dramrd_ack = 1'b0; dramra_rdy = 1'b0; dramw_rdy = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
